ram_rd_dma_top: RTL and testbench
=================================

RAM_RD_DMA_TOP -- requirements
Module: ram_rd_dma_top

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 10, RAM address width; mailbox address = 2^RAM_ADDR_WIDTH-1.
REQ-002 SHALL have parameter RAM_DATA_WIDTH, default 32, RAM and output data width.
REQ-003 SHALL have parameter RD_WAIT, default 2, number of cycles per RAM read access (minimum 1).
REQ-004 SHALL have parameter OFIFO_DEPTH, default 4, output FIFO entries (power of 2).
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 ram_rd_addr_r  out  RAM_ADDR_WIDTH  right-port RAM address.
REQ-009 CE_bar_r  out  1  right-port chip enable, active-low.
REQ-010 RW_bar_r  out  1  right-port read/write, held 1 (read only).
REQ-011 OE_bar_r  out  1  right-port output enable, active-low.
REQ-012 BUSY_bar_r  in  1  port-contention busy, active-low.
REQ-013 INTR_bar_r  in  1  mailbox interrupt, active-low, level.
REQ-014 ram_rd_data_r  in  RAM_DATA_WIDTH  right-port read data.
REQ-015 out_data  out  RAM_DATA_WIDTH  FIFO head entry.
REQ-016 out_vld  out  1  FIFO non-empty.
REQ-017 out_rdy  in  1  consumer accepts; pop on out_vld & out_rdy.
REQ-018 batch_rd_done  out  1  one-cycle pulse, batch complete.

Function
REQ-019 SHALL implement FSM states IDLE, MBOX_RD, DATA_RD, DONE.
REQ-020 IDLE -> MBOX_RD when INTR_bar_r sampled 0; otherwise stay in IDLE.
REQ-021 Read access: address stable, CE_bar_r=0, OE_bar_r=0 for RD_WAIT cycles; data sampled on the last cycle.
REQ-022 If BUSY_bar_r=0 on the sample cycle, SHALL discard the data, keep the address, and restart the RD_WAIT count.
REQ-023 CE_bar_r and OE_bar_r SHALL be 1 in every cycle outside an access.
REQ-024 MBOX_RD reads the mailbox address; count N = ram_rd_data_r[RAM_ADDR_WIDTH-1:0], clamped to 2^RAM_ADDR_WIDTH-1.
REQ-025 After MBOX_RD: N=0 -> DONE; otherwise -> DATA_RD with remaining = N.
REQ-026 DATA_RD SHALL start an access only when FIFO occupancy < OFIFO_DEPTH; otherwise hold with CE_bar_r=1.
REQ-027 Each completed data access pushes the data into the FIFO, increments rd_ptr, and decrements remaining; remaining=0 -> DONE.
REQ-028 rd_ptr SHALL wrap from 2^RAM_ADDR_WIDTH-2 to 0 and never address the mailbox; it persists across batches.
REQ-029 DONE: batch_rd_done=1 for exactly one cycle, then -> IDLE.
REQ-030 Read-to-FIFO latency: data SHALL be visible on out_data/out_vld the cycle after the sample cycle when the FIFO was empty.
REQ-031 On a simultaneous push and pop, FIFO occupancy SHALL be unchanged and data order SHALL be preserved.
REQ-032 out_data SHALL be held stable while out_vld=1 and out_rdy=0.

Reset
REQ-033 Reset SHALL force state IDLE, rd_ptr=0, remaining=0, FIFO empty, and access counter=0.
REQ-034 During and after reset: CE_bar_r=1, OE_bar_r=1, RW_bar_r=1, ram_rd_addr_r=0, out_vld=0, out_data=0, batch_rd_done=0.
REQ-035 Reset asserted mid-access or mid-batch SHALL abort the batch with no pulse, and the discarded entries SHALL not be re-read.

Configuration
REQ-036 Macro SCIACC_RD_ENTRY_CNT_EN defined: adds output total_rd_cnt[15:0], incremented per FIFO push, saturating at 0xFFFF, reset to 0.
REQ-037 Macro SCIACC_RD_ENTRY_CNT_EN undefined: port and counter absent, all other behaviour identical.

Verification
REQ-038 Mailbox=3, RAM[0..2]=A,B,C, out_rdy=1, BUSY_bar_r=1 -> out A,B,C in order, one batch_rd_done pulse, rd_ptr=3.
REQ-039 Mailbox=0 -> mailbox read only, no FIFO push, batch_rd_done pulse 1 cycle after the mailbox sample.
REQ-040 rd_ptr=1021 (AW=10), mailbox=4 -> reads addresses 1021,1022,0,1; address 1023 only on the mailbox read.
REQ-041 BUSY_bar_r=0 on the sample cycle of the 2nd entry -> the same address is re-accessed, no duplicate or missing output.
REQ-042 out_rdy=0, mailbox=6, OFIFO_DEPTH=4 -> 4 reads then CE_bar_r held 1; raising out_rdy resumes, all 6 entries delivered.
REQ-043 Reset asserted mid-DATA_RD -> all outputs at reset values next cycle; a new batch restarts with the mailbox read.

Source files
------------

// File: rtl/ram_rd_dma_top.sv
// Batch reader: reads a mailbox count from the right port of a dual-port RAM, then streams that many
// entries into an output FIFO. Define SCIACC_RD_ENTRY_CNT_EN to add the saturating total_rd_cnt output.
module ram_rd_dma_top #(
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned RAM_DATA_WIDTH = 32,
  parameter int unsigned RD_WAIT        = 2,
  parameter int unsigned OFIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr_r,
  output logic                      CE_bar_r,
  output logic                      RW_bar_r,
  output logic                      OE_bar_r,
  input  logic                      BUSY_bar_r,
  input  logic                      INTR_bar_r,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data_r,
  output logic [RAM_DATA_WIDTH-1:0] out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      batch_rd_done
`ifdef SCIACC_RD_ENTRY_CNT_EN
  ,output logic [15:0]              total_rd_cnt
`endif
);

  localparam int unsigned AW = RAM_ADDR_WIDTH;
  localparam int unsigned DW = RAM_DATA_WIDTH;
  localparam int unsigned CW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam int unsigned FW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned OW = $clog2(OFIFO_DEPTH + 1);
  localparam logic [AW-1:0] MBOX_ADDR = '1;
  localparam logic [AW-1:0] PTR_LAST  = MBOX_ADDR - 1'b1;

  typedef enum logic [1:0] {IDLE, MBOX_RD, DATA_RD, DONE} state_e;

  state_e          state_q;
  logic            acc_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   rem_q;
  logic            done_q;

  logic [DW-1:0]   fifo_mem [0:(2**FW)-1];
  logic [FW-1:0]   wr_idx_q;
  logic [FW-1:0]   rd_idx_q;
  logic [OW-1:0]   fcnt_q;

  logic            last_cyc;
  logic            sample_ok;
  logic            push;
  logic            pop;
  logic [AW-1:0]   mbox_n;
  logic [AW-1:0]   rd_ptr_nxt;

  assign last_cyc   = acc_q && (cnt_q == CW'(RD_WAIT - 1));
  assign sample_ok  = last_cyc && BUSY_bar_r;
  assign push       = sample_ok && (state_q == DATA_RD);
  assign pop        = (fcnt_q != '0) && out_rdy;
  // The clamp to the mailbox address is inherent: an AW-bit field cannot exceed 2^AW-1.
  assign mbox_n     = ram_rd_data_r[AW-1:0];
  assign rd_ptr_nxt = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc_q) begin
        // A busy sample restarts the count on the same address.
        cnt_q <= last_cyc ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (!INTR_bar_r) begin
            state_q <= MBOX_RD;
            acc_q   <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= MBOX_ADDR;
          end
        end
        MBOX_RD: begin
          if (sample_ok) begin
            acc_q <= 1'b0;
            if (mbox_n == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DATA_RD;
              rem_q   <= mbox_n;
            end
          end
        end
        DATA_RD: begin
          if (!acc_q) begin
            if (fcnt_q < OW'(OFIFO_DEPTH)) begin
              acc_q  <= 1'b1;
              cnt_q  <= '0;
              addr_q <= rd_ptr_q;
            end
          end else if (sample_ok) begin
            acc_q    <= 1'b0;
            rd_ptr_q <= rd_ptr_nxt;
            rem_q    <= rem_q - 1'b1;
            if (rem_q == AW'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_idx_q] <= ram_rd_data_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_idx_q <= wr_idx_q + 1'b1;
      if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

`ifdef SCIACC_RD_ENTRY_CNT_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
    end else if (push && (total_q != '1)) begin
      total_q <= total_q + 1'b1;
    end
  end

  assign total_rd_cnt = total_q;
`endif

  assign ram_rd_addr_r = addr_q;
  assign CE_bar_r      = ~acc_q;
  assign OE_bar_r      = ~acc_q;
  assign RW_bar_r      = 1'b1;
  assign batch_rd_done = done_q;
  assign out_vld       = (fcnt_q != '0);
  assign out_data      = out_vld ? fifo_mem[rd_idx_q] : '0;

endmodule

// File: tb/tb_ram_rd_dma_top.sv
// Directed bench for ram_rd_dma_top: RAM model, access/output monitor, one task per scenario.
module tb_ram_rd_dma_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  ram_rd_addr_r;
  logic        CE_bar_r, RW_bar_r, OE_bar_r;
  logic        BUSY_bar_r = 1'b1;
  logic        INTR_bar_r = 1'b1;
  logic [31:0] ram_rd_data_r;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic        batch_rd_done;
`ifdef SCIACC_RD_ENTRY_CNT_EN
  logic [15:0] total_rd_cnt;
`endif

  ram_rd_dma_top #(
    .RAM_ADDR_WIDTH(10),
    .RAM_DATA_WIDTH(32),
    .RD_WAIT(2),
    .OFIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(rst),
    .ram_rd_addr_r(ram_rd_addr_r),
    .CE_bar_r(CE_bar_r),
    .RW_bar_r(RW_bar_r),
    .OE_bar_r(OE_bar_r),
    .BUSY_bar_r(BUSY_bar_r),
    .INTR_bar_r(INTR_bar_r),
    .ram_rd_data_r(ram_rd_data_r),
    .out_data(out_data),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .batch_rd_done(batch_rd_done)
`ifdef SCIACC_RD_ENTRY_CNT_EN
    ,.total_rd_cnt(total_rd_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  assign ram_rd_data_r = ram[ram_rd_addr_r];

  int tests = 0;
  int failed = 0;

  logic [9:0]  alog[$];
  logic [31:0] outq[$];
  logic [9:0]  ea[$];
  logic [31:0] eo[$];
  int          done_cnt = 0;
  int          ce_low_cyc = 0;
  bit          done_after_ce = 1'b0;
  logic        ce_prev = 1'b1;

  // Monitor samples mid-cycle; inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (!CE_bar_r && ce_prev) alog.push_back(ram_rd_addr_r);
    if (!CE_bar_r) ce_low_cyc++;
    if (out_vld && out_rdy) outq.push_back(out_data);
    if (batch_rd_done) begin
      done_cnt++;
      done_after_ce = !ce_prev;
    end
    ce_prev = CE_bar_r;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    alog.delete();
    outq.delete();
    done_cnt = 0;
    ce_low_cyc = 0;
    done_after_ce = 1'b0;
  endtask

  task automatic start_batch(input logic [31:0] n);
    ram[1023] = n;
    clear_logs();
    INTR_bar_r = 1'b0;
    tick(1);
    INTR_bar_r = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if (done_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(4);
  endtask

  task automatic wait_access(input logic [9:0] a, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!CE_bar_r && ram_rd_addr_r == a) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  function automatic int alog_diff();
    int d = 0;
    if (alog.size() != ea.size()) return 1000 + alog.size();
    foreach (ea[i]) if (alog[i] !== ea[i]) d++;
    return d;
  endfunction

  function automatic int outq_diff();
    int d = 0;
    if (outq.size() != eo.size()) return 1000 + outq.size();
    foreach (eo[i]) if (outq[i] !== eo[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    tick(2);
    tests++; if (CE_bar_r !== 1'b1) begin failed++; $display("FAIL rst_ce: got %b want 1", CE_bar_r); end
    tests++; if (OE_bar_r !== 1'b1) begin failed++; $display("FAIL rst_oe: got %b want 1", OE_bar_r); end
    tests++; if (RW_bar_r !== 1'b1) begin failed++; $display("FAIL rst_rw: got %b want 1", RW_bar_r); end
    tests++; if (ram_rd_addr_r !== 10'd0) begin failed++; $display("FAIL rst_addr: got %0d want 0", ram_rd_addr_r); end
    tests++; if (out_vld !== 1'b0) begin failed++; $display("FAIL rst_vld: got %b want 0", out_vld); end
    tests++; if (out_data !== 32'd0) begin failed++; $display("FAIL rst_data: got %h want 0", out_data); end
    tests++; if (batch_rd_done !== 1'b0) begin failed++; $display("FAIL rst_done: got %b want 0", batch_rd_done); end
    rst = 1'b0;
    tick(3);
    tests++; if (CE_bar_r !== 1'b1) begin failed++; $display("FAIL idle_ce: got %b want 1", CE_bar_r); end
  endtask

  task automatic test_basic();
    bit ok;
    start_batch(32'd3);
    wait_done(ok);
    ea = '{10'd1023, 10'd0, 10'd1, 10'd2};
    eo = '{ram[0], ram[1], ram[2]};
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL basic_done_seen: got %b want 1", ok); end
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL basic_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq_diff() !== 0) begin failed++; $display("FAIL basic_data: got %0d diffs want 0", outq_diff()); end
    tests++; if (done_cnt !== 1) begin failed++; $display("FAIL basic_pulse: got %0d cycles want 1", done_cnt); end
  endtask

  task automatic test_zero_count();
    bit ok;
    start_batch(32'd0);
    wait_done(ok);
    ea = '{10'd1023};
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL zero_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq.size() !== 0) begin failed++; $display("FAIL zero_push: got %0d entries want 0", outq.size()); end
    tests++; if (done_cnt !== 1) begin failed++; $display("FAIL zero_pulse: got %0d cycles want 1", done_cnt); end
    tests++; if (done_after_ce !== 1'b1) begin failed++; $display("FAIL zero_latency: got %b want 1", done_after_ce); end
  endtask

  task automatic test_long_batch();
    bit ok;
    int bad = 0;
    start_batch(32'd1018);
    wait_done(ok);
    tests++; if (outq.size() !== 1018) begin failed++; $display("FAIL long_count: got %0d want 1018", outq.size()); end
    foreach (outq[i]) if (i < 1018 && outq[i] !== ram[3 + i]) bad++;
    tests++; if (bad !== 0) begin failed++; $display("FAIL long_data: got %0d bad want 0", bad); end
    tests++; if (alog.size() !== 1019 || alog[alog.size()-1] !== 10'd1020)
      begin failed++; $display("FAIL long_last_addr: got size %0d want 1019 ending 1020", alog.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    start_batch(32'd4);
    wait_done(ok);
    ea = '{10'd1023, 10'd1021, 10'd1022, 10'd0, 10'd1};
    eo = '{ram[1021], ram[1022], ram[0], ram[1]};
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL wrap_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq_diff() !== 0) begin failed++; $display("FAIL wrap_data: got %0d diffs want 0", outq_diff()); end
  endtask

  task automatic test_busy_retry();
    bit ok;
    start_batch(32'd3);
    wait_access(10'd3, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL busy_reach: got %b want 1", ok); end
    BUSY_bar_r = 1'b0;
    tick(4);
    BUSY_bar_r = 1'b1;
    wait_done(ok);
    ea = '{10'd1023, 10'd2, 10'd3, 10'd4};
    eo = '{ram[2], ram[3], ram[4]};
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL busy_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq_diff() !== 0) begin failed++; $display("FAIL busy_data: got %0d diffs want 0", outq_diff()); end
    tests++; if (ce_low_cyc !== 12) begin failed++; $display("FAIL busy_ce_cycles: got %0d want 12", ce_low_cyc); end
    tests++; if (done_cnt !== 1) begin failed++; $display("FAIL busy_pulse: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    out_rdy = 1'b0;
    start_batch(32'd6);
    tick(40);
    tests++; if (alog.size() !== 5) begin failed++; $display("FAIL bp_stall_reads: got %0d want 5", alog.size()); end
    tests++; if (CE_bar_r !== 1'b1) begin failed++; $display("FAIL bp_ce_held: got %b want 1", CE_bar_r); end
    tests++; if (out_vld !== 1'b1) begin failed++; $display("FAIL bp_vld: got %b want 1", out_vld); end
    tick(3);
    tests++; if (out_data !== ram[5]) begin failed++; $display("FAIL bp_hold: got %h want %h", out_data, ram[5]); end
    tests++; if (done_cnt !== 0) begin failed++; $display("FAIL bp_early_done: got %0d want 0", done_cnt); end
    out_rdy = 1'b1;
    wait_done(ok);
    ea = '{10'd1023, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9, 10'd10};
    eo = '{ram[5], ram[6], ram[7], ram[8], ram[9], ram[10]};
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL bp_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq_diff() !== 0) begin failed++; $display("FAIL bp_data: got %0d diffs want 0", outq_diff()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_batch(32'd8);
    wait_access(10'd12, ok);
    tests++; if (ok !== 1'b1) begin failed++; $display("FAIL rmid_reach: got %b want 1", ok); end
    rst = 1'b1;
    #2;
    tests++; if (CE_bar_r !== 1'b1 || OE_bar_r !== 1'b1) begin failed++; $display("FAIL rmid_ce_oe: got %b%b want 11", CE_bar_r, OE_bar_r); end
    tests++; if (ram_rd_addr_r !== 10'd0) begin failed++; $display("FAIL rmid_addr: got %0d want 0", ram_rd_addr_r); end
    tests++; if (out_vld !== 1'b0 || out_data !== 32'd0) begin failed++; $display("FAIL rmid_out: got %b/%h want 0/0", out_vld, out_data); end
    tick(2);
    rst = 1'b0;
    tick(3);
    tests++; if (done_cnt !== 0) begin failed++; $display("FAIL rmid_no_pulse: got %0d want 0", done_cnt); end
    start_batch(32'd2);
    wait_done(ok);
    ea = '{10'd1023, 10'd0, 10'd1};
    eo = '{ram[0], ram[1]};
    tests++; if (alog_diff() !== 0) begin failed++; $display("FAIL rmid_addrs: got %0d diffs want 0", alog_diff()); end
    tests++; if (outq_diff() !== 0) begin failed++; $display("FAIL rmid_data: got %0d diffs want 0", outq_diff()); end
    tests++; if (done_cnt !== 1) begin failed++; $display("FAIL rmid_pulse: got %0d want 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hD000_0000 + 32'(i) * 32'd7;
    #1;
    test_reset();
    test_basic();
    test_zero_count();
    test_long_batch();
    test_wrap();
    test_busy_retry();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
